// File: rtl/door_motor_ctrl_if.sv
// Door actuator signal bundle.
// master: greenhouse controller / sensor side, drives requests, PIRs, limits, fault_clr.
// slave : door_motor_ctrl, drives motor_open, motor_close, door_state, fault.
interface door_motor_ctrl_if;
   logic       open_req;
   logic       close_req;
   logic       pir_in;
   logic       pir_out;
   logic       open_max;
   logic       close_max;
   logic       fault_clr;
   logic       motor_open;
   logic       motor_close;
   logic [2:0] door_state;
   logic       fault;

   modport master (
      output open_req, close_req, pir_in, pir_out, open_max, close_max, fault_clr,
      input  motor_open, motor_close, door_state, fault
   );

   modport slave (
      input  open_req, close_req, pir_in, pir_out, open_max, close_max, fault_clr,
      output motor_open, motor_close, door_state, fault
   );
endinterface

// File: rtl/door_motor_ctrl.sv
// Door motor sequencer: open / hold / close phases with hold-open timer, obstruction
// reversal on presence while closing, and a latched fault on motion timeout or both
// limit switches asserted together.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - door_motor_ctrl_if.slave: requests, PIRs, limit switches, fault_clr in;
//           motor_open, motor_close, door_state, fault out
// Outputs are registered copies of the next-state decode, so they equal a decode of the
// state register and have no combinational path from any input.
module door_motor_ctrl #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned HOLD_CYCLES  = 1000,
   parameter int unsigned MOVE_TIMEOUT = 5000
) (
   input  logic               clk,
   input  logic               rst_n,
   door_motor_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      StInit     = 3'd0,
      StClosed   = 3'd1,
      StOpening  = 3'd2,
      StOpenHold = 3'd3,
      StClosing  = 3'd4,
      StFault    = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] MoveLast = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             motor_open_q, motor_close_q, fault_q;
   logic [2:0]       door_state_q;
   logic             pres, lim_err;

   // open_req counts as presence so a simultaneous open/close request always opens.
   assign pres    = bus.pir_in | bus.pir_out | bus.open_req;
   assign lim_err = bus.open_max & bus.close_max;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StInit: begin
            state_d = bus.close_max ? StClosed : StClosing;
         end
         StClosed: begin
            if (pres) state_d = StOpening;
         end
         StOpening: begin
            if (lim_err)               state_d = StFault;
            else if (bus.open_max)     state_d = StOpenHold;
            else if (cnt_q == MoveLast) state_d = StFault;
            else                       cnt_d = cnt_q + 1'b1;
         end
         StOpenHold: begin
            if (pres)                   state_d = StOpenHold;  // re-arm hold timer
            else if (bus.close_req)     state_d = StClosing;
            else if (cnt_q == HoldLast) state_d = StClosing;
            else                        cnt_d = cnt_q + 1'b1;
         end
         StClosing: begin
            if (lim_err)                state_d = StFault;
            else if (pres)              state_d = StOpening;   // reversal beats close_max
            else if (bus.close_max)     state_d = StClosed;
            else if (cnt_q == MoveLast) state_d = StFault;
            else                        cnt_d = cnt_q + 1'b1;
         end
         StFault: begin
            if (bus.fault_clr) state_d = StInit;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StInit;
         cnt_q         <= '0;
         motor_open_q  <= 1'b0;
         motor_close_q <= 1'b0;
         fault_q       <= 1'b0;
         door_state_q  <= 3'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         motor_open_q  <= (state_d == StOpening);
         motor_close_q <= (state_d == StClosing);
         fault_q       <= (state_d == StFault);
         door_state_q  <= state_d;
      end
   end

   assign bus.motor_open  = motor_open_q;
   assign bus.motor_close = motor_close_q;
   assign bus.fault       = fault_q;
   assign bus.door_state  = door_state_q;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Self-checking bench for door_motor_ctrl (HOLD_CYCLES=8, MOVE_TIMEOUT=20).
module tb_door_motor_ctrl;

   localparam logic [2:0] S_INIT = 3'd0, S_CLOSED = 3'd1, S_OPENING = 3'd2,
                          S_HOLD = 3'd3, S_CLOSING = 3'd4, S_FAULT = 3'd5;

   // input bit order: {open_req, close_req, pir_in, pir_out, open_max, close_max, fault_clr}
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_OREQ = 7'b1000000;
   localparam logic [6:0] I_CREQ = 7'b0100000;
   localparam logic [6:0] I_PIN  = 7'b0010000;
   localparam logic [6:0] I_POUT = 7'b0001000;
   localparam logic [6:0] I_OMAX = 7'b0000100;
   localparam logic [6:0] I_CMAX = 7'b0000010;
   localparam logic [6:0] I_FCLR = 7'b0000001;

   typedef struct {
      logic [6:0] ins;
      logic [2:0] exp_state;
      string      name;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [2:0] sb[$];
   vec_t tbl[$];

   door_motor_ctrl_if bus();

   door_motor_ctrl #(
      .CNT_W       (16),
      .HOLD_CYCLES (8),
      .MOVE_TIMEOUT(20)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Motors must never be driven both ways.
   always @(negedge clk) begin
      checks++;
      if (bus.motor_open && bus.motor_close) begin
         errors++;
         $display("FAIL motor_exclusive got open=%0b close=%0b required not both 1",
                  bus.motor_open, bus.motor_close);
      end
   end

   function automatic vec_t v(input logic [6:0] ins, input logic [2:0] s, input string n);
      vec_t r;
      r.ins = ins; r.exp_state = s; r.name = n;
      return r;
   endfunction

   task automatic drive(input logic [6:0] ins);
      {bus.open_req, bus.close_req, bus.pir_in, bus.pir_out,
       bus.open_max, bus.close_max, bus.fault_clr} = ins;
   endtask

   // Compare all outputs against the expected state and its required output decode.
   task automatic cmp(input logic [2:0] s, input string name);
      logic [5:0] got, req;
      got = {bus.door_state, bus.motor_open, bus.motor_close, bus.fault};
      req = {s, s == S_OPENING, s == S_CLOSING, s == S_FAULT};
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got state=%0d mo=%0b mc=%0b f=%0b required state=%0d mo=%0b mc=%0b f=%0b",
                  name, got[5:3], got[2], got[1], got[0], req[5:3], req[2], req[1], req[0]);
      end
   endtask

   // Called at a negedge; drives, pushes expectation, checks after the next posedge,
   // returns at the following negedge.
   task automatic step(input logic [6:0] ins, input logic [2:0] s, input string name);
      logic [2:0] e;
      drive(ins);
      sb.push_back(s);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp(e, name);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(I_CMAX);
      #3;
      cmp(S_INIT, "reset_state");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cmp(S_INIT, "init_after_release");

      // Tests 1, 2 and 4 as a vector table.
      tbl.push_back(v(I_CMAX,               S_CLOSED,  "t1_init_to_closed"));
      tbl.push_back(v(I_CMAX,               S_CLOSED,  "t2_closed_idle"));
      tbl.push_back(v(I_CREQ | I_CMAX,      S_CLOSED,  "t2_close_req_stays"));
      tbl.push_back(v(I_OMAX | I_CMAX,      S_CLOSED,  "t2_limits_ignored_closed"));
      tbl.push_back(v(I_PIN | I_CMAX,       S_OPENING, "t2_pir_in_opens"));
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(I_NONE,            S_OPENING, "t2_opening"));
      tbl.push_back(v(I_OMAX,               S_HOLD,    "t2_open_max_hold"));
      for (int i = 0; i < 7; i++)
         tbl.push_back(v((i == 3) ? I_CMAX : I_NONE, S_HOLD, "t2_hold_wait"));
      tbl.push_back(v(I_NONE,               S_CLOSING, "t2_hold_expire"));
      tbl.push_back(v(I_NONE,               S_CLOSING, "t2_closing"));
      tbl.push_back(v(I_CMAX,               S_CLOSED,  "t2_closed_again"));
      tbl.push_back(v(I_OREQ | I_CREQ | I_CMAX, S_OPENING, "t4_open_beats_close"));
      tbl.push_back(v(I_OMAX,               S_HOLD,    "t4_hold"));
      tbl.push_back(v(I_CREQ,               S_CLOSING, "t4_close_req"));
      tbl.push_back(v(I_PIN | I_CMAX,       S_OPENING, "t4_reversal_wins"));
      tbl.push_back(v(I_OMAX,               S_HOLD,    "t4_hold2"));
      tbl.push_back(v(I_OREQ | I_CREQ,      S_HOLD,    "t4_pres_rearms"));
      tbl.push_back(v(I_CREQ,               S_CLOSING, "t4_close_req2"));
      tbl.push_back(v(I_CMAX,               S_CLOSED,  "t4_closed"));
      foreach (tbl[i]) step(tbl[i].ins, tbl[i].exp_state, tbl[i].name);

      // Test 3: presence pulse at hold cycle 6 restarts the hold count.
      step(I_POUT | I_CMAX, S_OPENING, "t3_open");
      step(I_OMAX, S_HOLD, "t3_hold");
      for (int i = 0; i < 6; i++) step(I_NONE, S_HOLD, "t3_hold_pre");
      step(I_POUT, S_HOLD, "t3_pulse");
      for (int i = 0; i < 7; i++) step(I_NONE, S_HOLD, "t3_hold_post");
      step(I_NONE, S_CLOSING, "t3_expire");
      step(I_CMAX, S_CLOSED, "t3_closed");

      // Test 5: open timeout after exactly 20 cycles in OPENING, fault latched.
      step(I_PIN | I_CMAX, S_OPENING, "t5_open");
      for (int i = 0; i < 19; i++) step(I_OREQ, S_OPENING, "t5_opening");
      step(I_NONE, S_FAULT, "t5_timeout");
      step(I_OREQ, S_FAULT, "t5_ignore_oreq");
      step(I_PIN | I_POUT | I_CREQ, S_FAULT, "t5_ignore_pir");
      step(I_FCLR, S_INIT, "t5_fault_clr");
      step(I_NONE, S_CLOSING, "t5_init_to_closing");
      step(I_CMAX, S_CLOSED, "t5_closed");

      // Test 6: asynchronous reset mid-motion, then limit error while closing/opening.
      step(I_PIN | I_CMAX, S_OPENING, "t6_open");
      #2;
      rst_n = 1'b0;
      #1;
      cmp(S_INIT, "t6_async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step(I_NONE, S_CLOSING, "t6_rehome_closing");
      step(I_OMAX | I_CMAX, S_FAULT, "t6_lim_err_closing");
      step(I_FCLR | I_OMAX | I_CMAX, S_INIT, "t6_clr");
      step(I_CMAX, S_CLOSED, "t6_closed");
      step(I_PIN | I_CMAX, S_OPENING, "t6_open2");
      step(I_OMAX | I_CMAX, S_FAULT, "t6_lim_err_opening");
      step(I_FCLR, S_INIT, "t6_clr2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
